// File: rtl/perip_responder.sv
// CPU peripheral-bus responder: byte-writable data RAM plus an MMIO window holding
// DIP switches, LEDs, a scanned 7-segment data register and a start/stop cycle counter.
module perip_responder #(
  parameter int unsigned DRAM_AW   = 14,
  parameter logic [31:0] DRAM_BASE = 32'h8010_0000,
  parameter logic [31:0] MMIO_BASE = 32'h8020_0000,
  parameter logic [15:0] SCAN_DIV  = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] perip_addr,
  input  logic [31:0] perip_wdata,
  input  logic        perip_wen,
  input  logic [1:0]  perip_mask,
  output logic [31:0] perip_rdata,
  input  logic [6:0]  dip,
  output logic [15:0] led,
  output logic [31:0] seg_data,
  output logic [7:0]  seg_an,
  output logic [3:0]  seg_nibble
);

  typedef enum logic [0:0] {StIdle, StRun} cnt_st_e;

  logic [31:0]        dram_q [2**DRAM_AW];
  logic [31:0]        dram_off, mmio_off;
  logic [DRAM_AW-1:0] dram_idx;
  logic               dram_hit, mmio_hit, sw_hit, seg_hit, led_hit, cnt_hit;
  logic [3:0]         lane_be;
  logic [31:0]        lane_data, lane_bits;
  logic               word_wr, cnt_start, cnt_stop;

  logic [6:0]  dip_meta_q, dip_sync_q;
  logic [15:0] led_q, led_d;
  logic [31:0] seg_q, seg_d;
  logic [31:0] cnt_q, cnt_d;
  cnt_st_e     cnt_st_q, cnt_st_d;
  logic [15:0] presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  seg_an_q, seg_an_d;
  logic [3:0]  seg_nibble_q, seg_nibble_d;

  // Address decode and store lane steering
  always_comb begin
    dram_off = perip_addr - DRAM_BASE;
    mmio_off = perip_addr - MMIO_BASE;
    dram_hit = dram_off < (32'd4 << DRAM_AW);
    mmio_hit = mmio_off < 32'h100;
    dram_idx = dram_off[DRAM_AW+1:2];
    sw_hit   = mmio_hit && (mmio_off[7:2] == 6'h00);
    seg_hit  = mmio_hit && (mmio_off[7:2] == 6'h08);
    led_hit  = mmio_hit && (mmio_off[7:2] == 6'h10);
    cnt_hit  = mmio_hit && (mmio_off[7:2] == 6'h14);

    lane_be   = 4'b0000;
    lane_data = perip_wdata;
    case (perip_mask)
      2'b00: begin
        lane_be   = 4'b0001 << perip_addr[1:0];
        lane_data = {4{perip_wdata[7:0]}};
      end
      2'b01: begin
        lane_be   = perip_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{perip_wdata[15:0]}};
      end
      2'b10:   lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
    lane_bits = {{8{lane_be[3]}}, {8{lane_be[2]}}, {8{lane_be[1]}}, {8{lane_be[0]}}};
    word_wr   = perip_wen && (perip_mask != 2'b11);
  end

  // Reads see only registered state, so a same-cycle store shows old data
  always_comb begin
    perip_rdata = 32'h0;
    if (dram_hit)     perip_rdata = dram_q[dram_idx];
    else if (sw_hit)  perip_rdata = {25'b0, dip_sync_q};
    else if (seg_hit) perip_rdata = seg_q;
    else if (led_hit) perip_rdata = {16'b0, led_q};
    else if (cnt_hit) perip_rdata = cnt_q;
  end

  always_comb begin
    led_d = led_q;
    if (word_wr && led_hit) led_d = perip_wdata[15:0];

    seg_d = seg_q;
    if (perip_wen && seg_hit) seg_d = (seg_q & ~lane_bits) | (lane_data & lane_bits);

    cnt_start = word_wr && cnt_hit && (perip_wdata == 32'h8000_0000);
    cnt_stop  = word_wr && cnt_hit && (perip_wdata == 32'hFFFF_FFFF);
    cnt_st_d  = cnt_st_q;
    cnt_d     = cnt_q;
    unique case (cnt_st_q)
      StIdle: cnt_d = cnt_q;
      StRun:  cnt_d = cnt_q + 32'd1;
      default: cnt_d = cnt_q;
    endcase
    if (cnt_stop) begin
      cnt_st_d = StIdle;
      cnt_d    = cnt_q;
    end
    if (cnt_start) begin
      cnt_st_d = StRun;
      cnt_d    = 32'h0;
    end

    presc_d = presc_q + 16'd1;
    idx_d   = idx_q;
    if (presc_q == SCAN_DIV - 16'd1) begin
      presc_d = 16'h0;
      idx_d   = idx_q + 3'd1;
    end
    // Enable and nibble come from the same next index so they switch on one edge
    seg_an_d     = ~(8'b1 << idx_d);
    seg_nibble_d = seg_d[{idx_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dip_meta_q   <= 7'h0;
      dip_sync_q   <= 7'h0;
      led_q        <= 16'h0;
      seg_q        <= 32'h0;
      cnt_q        <= 32'h0;
      cnt_st_q     <= StIdle;
      presc_q      <= 16'h0;
      idx_q        <= 3'h0;
      seg_an_q     <= 8'hFE;
      seg_nibble_q <= 4'h0;
    end else begin
      dip_meta_q   <= dip;
      dip_sync_q   <= dip_meta_q;
      led_q        <= led_d;
      seg_q        <= seg_d;
      cnt_q        <= cnt_d;
      cnt_st_q     <= cnt_st_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      seg_an_q     <= seg_an_d;
      seg_nibble_q <= seg_nibble_d;
    end
  end

  // RAM contents survive reset; stores during reset are dropped
  always_ff @(posedge clk) begin
    if (rst_n && perip_wen && dram_hit && (lane_be != 4'b0000)) begin
      dram_q[dram_idx] <= (dram_q[dram_idx] & ~lane_bits) | (lane_data & lane_bits);
    end
  end

  assign led        = led_q;
  assign seg_data   = seg_q;
  assign seg_an     = seg_an_q;
  assign seg_nibble = seg_nibble_q;

endmodule

// File: tb/tb_perip_responder.sv
// Directed bench for perip_responder: RAM lanes, MMIO registers, counter, DIP sync,
// scan sequencing and reset behaviour, against hand-computed expectations.
module tb_perip_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] perip_addr, perip_wdata, perip_rdata;
  logic        perip_wen;
  logic [1:0]  perip_mask;
  logic [6:0]  dip;
  logic [15:0] led;
  logic [31:0] seg_data;
  logic [7:0]  seg_an;
  logic [3:0]  seg_nibble;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] Sw  = 32'h8020_0000;
  localparam logic [31:0] Seg = 32'h8020_0020;
  localparam logic [31:0] Led = 32'h8020_0040;
  localparam logic [31:0] Cnt = 32'h8020_0050;

  perip_responder #(.SCAN_DIV(16'd2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .perip_addr (perip_addr),
    .perip_wdata(perip_wdata),
    .perip_wen  (perip_wen),
    .perip_mask (perip_mask),
    .perip_rdata(perip_rdata),
    .dip        (dip),
    .led        (led),
    .seg_data   (seg_data),
    .seg_an     (seg_an),
    .seg_nibble (seg_nibble)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
    perip_addr  = a;
    perip_wdata = d;
    perip_mask  = m;
    perip_wen   = 1'b1;
    @(posedge clk);
    #1;
    perip_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    perip_addr = a;
    perip_wen  = 1'b0;
    #1;
    d = perip_rdata;
  endtask

  logic [31:0] rd;
  logic [7:0]  prev_an, exp_an;
  logic [31:0] seg_model;
  bit          found;

  initial begin
    rst_n = 1'b0; perip_addr = 32'h0; perip_wdata = 32'h0; perip_wen = 1'b0;
    perip_mask = 2'b10; dip = 7'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_seg_data", seg_data, 32'h0);
    check("rst_seg_an", {24'h0, seg_an}, 32'h0000_00FE);
    check("rst_seg_nibble", {28'h0, seg_nibble}, 32'h0);
    bus_read(Cnt, rd); check("rst_cnt", rd, 32'h0);
    bus_read(Sw, rd);  check("rst_sw", rd, 32'h0);
    rst_n = 1'b1;

    // RAM word then byte, with old data visible while the byte store is pending
    bus_write(32'h8010_0004, 32'h1122_3344, 2'b10);
    perip_addr = 32'h8010_0005; perip_wdata = 32'hAB; perip_mask = 2'b00; perip_wen = 1'b1;
    #1;
    check("rdw_old", perip_rdata, 32'h1122_3344);
    @(posedge clk); #1; perip_wen = 1'b0;
    bus_read(32'h8010_0004, rd); check("sb_lane1", rd, 32'h1122_AB44);

    // Half stores: addr[1] picks the half, addr[0] ignored; mask 11 drops
    bus_write(32'h8010_0008, 32'h0, 2'b10);
    bus_write(32'h8010_000A, 32'h0000_BEEF, 2'b01);
    bus_read(32'h8010_0008, rd); check("sh_upper", rd, 32'hBEEF_0000);
    bus_write(32'h8010_0009, 32'hFFFF_1234, 2'b01);
    bus_read(32'h8010_0008, rd); check("sh_lower_a0", rd, 32'hBEEF_1234);
    bus_write(32'h8010_000B, 32'h0000_005A, 2'b00);
    bus_read(32'h8010_0008, rd); check("sb_lane3", rd, 32'h5AEF_1234);
    bus_write(32'h8010_0008, 32'hFFFF_FFFF, 2'b11);
    bus_read(32'h8010_0008, rd); check("mask11_drop", rd, 32'h5AEF_1234);

    // RAM window edges: last word inside, first word past the end is unmapped
    bus_write(32'h8010_0000, 32'hCAFE_F00D, 2'b10);
    bus_write(32'h8010_FFFC, 32'h0BAD_BEEF, 2'b10);
    bus_read(32'h8010_FFFC, rd); check("dram_top", rd, 32'h0BAD_BEEF);
    bus_write(32'h8011_0000, 32'h1234_5678, 2'b10);
    bus_read(32'h8011_0000, rd); check("past_dram", rd, 32'h0);
    bus_read(32'h8010_0000, rd); check("no_alias", rd, 32'hCAFE_F00D);
    bus_read(32'h8030_0000, rd); check("unmapped", rd, 32'h0);
    bus_read(32'h8020_0010, rd); check("mmio_hole", rd, 32'h0);

    // LED takes word semantics whatever the size
    bus_write(Led, 32'h1234_ABCD, 2'b00);
    check("led_out", {16'h0, led}, 32'h0000_ABCD);
    bus_read(Led, rd); check("led_read", rd, 32'h0000_ABCD);

    // Counter start, run, stop, restart
    bus_write(Cnt, 32'h8000_0000, 2'b10);
    bus_read(Cnt, rd); check("cnt_start", rd, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    bus_read(Cnt, rd); check("cnt_10", rd, 32'd10);
    bus_write(Cnt, 32'hFFFF_FFFF, 2'b10);
    bus_read(Cnt, rd); check("cnt_stop", rd, 32'd10);
    repeat (5) @(posedge clk);
    #1;
    bus_read(Cnt, rd); check("cnt_frozen", rd, 32'd10);
    bus_write(Cnt, 32'h1234_5678, 2'b10);
    repeat (2) @(posedge clk);
    #1;
    bus_read(Cnt, rd); check("cnt_other_ign", rd, 32'd10);
    bus_write(Cnt, 32'h8000_0000, 2'b10);
    repeat (3) @(posedge clk);
    #1;
    bus_read(Cnt, rd); check("cnt_run3", rd, 32'd3);
    bus_write(Cnt, 32'h8000_0000, 2'b10);
    bus_read(Cnt, rd); check("cnt_restart", rd, 32'h0);

    // DIP synchroniser latency
    dip = 7'h55;
    bus_read(Sw, rd); check("dip_edge0", rd, 32'h0);
    @(posedge clk); #1;
    bus_read(Sw, rd); check("dip_edge1", rd, 32'h0);
    @(posedge clk); #1;
    bus_read(Sw, rd); check("dip_edge2", rd, 32'h55);
    bus_write(Sw, 32'hFFFF_FFFF, 2'b10);
    bus_read(Sw, rd); check("sw_ro", rd, 32'h55);

    // Scan: align to the 7F->FE wrap, then walk nine 2-cycle digit windows
    seg_model = 32'h8765_4321;
    bus_write(Seg, seg_model, 2'b10);
    check("seg_write", seg_data, seg_model);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev_an = seg_an;
      @(posedge clk); #1;
      if (prev_an == 8'h7F && seg_an == 8'hFE) found = 1'b1;
    end
    check("scan_sync", {31'h0, found}, 32'h1);
    for (int k = 0; k < 9; k++) begin
      exp_an = ~(8'b1 << (k % 8));
      for (int c = 0; c < 2; c++) begin
        check($sformatf("scan_an_%0d_%0d", k, c), {24'h0, seg_an}, {24'h0, exp_an});
        check($sformatf("scan_nib_%0d_%0d", k, c), {28'h0, seg_nibble},
              (seg_model >> (4 * (k % 8))) & 32'hF);
        @(posedge clk); #1;
      end
    end
    bus_write(Seg + 32'd1, 32'h0000_0099, 2'b00);
    bus_read(Seg, rd); check("seg_sb", rd, 32'h8765_9921);

    // Reset mid-run with an LED store pending, then a RAM store during reset
    bus_write(Cnt, 32'h8000_0000, 2'b10);
    repeat (4) @(posedge clk);
    #1;
    perip_addr = Led; perip_wdata = 32'h0000_FFFF; perip_mask = 2'b10; perip_wen = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_led_drop", {16'h0, led}, 32'h0);
    check("rst_seg_clr", seg_data, 32'h0);
    check("rst_an", {24'h0, seg_an}, 32'h0000_00FE);
    perip_addr = 32'h8010_0004; perip_wdata = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1; perip_wen = 1'b0;
    bus_read(Cnt, rd); check("rst_cnt_zero", rd, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    bus_read(Cnt, rd); check("rst_cnt_idle", rd, 32'h0);
    bus_read(32'h8010_0004, rd); check("rst_dram_keep", rd, 32'h1122_AB44);
    bus_read(32'h8010_0008, rd); check("rst_dram_keep2", rd, 32'h5AEF_1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
